// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, I/D-cache miss and
// taken-branch sources into per-stage hold/bubble controls, with cache-wait FSM and watchdog.
module pipeline_stall_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_mem_read_in,
    input  logic [4:0]       ex_reg_dest_addr_in,
    input  logic [4:0]       id_reg_a_addr_in,
    input  logic [4:0]       id_reg_b_addr_in,
    input  logic             ex_branch_taken_in,
    input  logic             ic_req_in,
    input  logic             ic_ready_in,
    input  logic             dc_req_in,
    input  logic             dc_ready_in,
    output logic             pc_stall_out,
    output logic             if_id_stall_out,
    output logic             id_ex_stall_out,
    output logic             ex_mem_stall_out,
    output logic             if_id_flush_out,
    output logic             id_ex_flush_out,
    output logic             mem_wb_flush_out,
    output logic             ic_abort_out,
    output logic [1:0]       state_out,
    output logic [CNT_W-1:0] stall_count_out,
    output logic             timeout_out
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        IC_WAIT = 2'd1,
        DC_WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic id_ex_stall;
        logic ex_mem_stall;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_flush;
        logic ic_abort;
    } ctrl_t;

    state_e            state, state_nxt;
    ctrl_t             ctrl;
    logic              lu, dm, im, br;
    logic [WAIT_W-1:0] wait_cnt, wait_inc;
    logic [CNT_W-1:0]  stall_cnt;
    logic              tmo;

    assign lu = ex_mem_read_in && (ex_reg_dest_addr_in != 5'd0) &&
                ((ex_reg_dest_addr_in == id_reg_a_addr_in) ||
                 (ex_reg_dest_addr_in == id_reg_b_addr_in));
    assign dm = dc_req_in && !dc_ready_in;
    assign im = ic_req_in && !ic_ready_in;
    assign br = ex_branch_taken_in;

    // One action per cycle, priority dm > br > lu > im.
    always_comb begin
        ctrl = '0;
        if (dm) begin
            ctrl.pc_stall     = 1'b1;
            ctrl.if_id_stall  = 1'b1;
            ctrl.id_ex_stall  = 1'b1;
            ctrl.ex_mem_stall = 1'b1;
            ctrl.mem_wb_flush = 1'b1;
        end else if (br) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
            ctrl.ic_abort    = im || (state == IC_WAIT);
        end else if (lu) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_stall = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (im) begin
            ctrl.pc_stall    = 1'b1;
            ctrl.if_id_flush = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (dm)             state_nxt = DC_WAIT;
                else if (im && !br) state_nxt = IC_WAIT;
            end
            IC_WAIT: begin
                if (dm)                     state_nxt = DC_WAIT;
                else if (ic_ready_in || br) state_nxt = RUN;
            end
            DC_WAIT: begin
                if (dc_ready_in) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Count of consecutive cycles in the current wait state, including this one.
    assign wait_inc = (wait_cnt == WAIT_W'(TIMEOUT)) ? wait_cnt : wait_cnt + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            tmo       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ctrl.pc_stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (state == RUN || state_nxt != state)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_inc;
            if (state != RUN && wait_inc >= WAIT_W'(TIMEOUT))
                tmo <= 1'b1;
        end
    end

    assign pc_stall_out     = reset && ctrl.pc_stall;
    assign if_id_stall_out  = reset && ctrl.if_id_stall;
    assign id_ex_stall_out  = reset && ctrl.id_ex_stall;
    assign ex_mem_stall_out = reset && ctrl.ex_mem_stall;
    assign if_id_flush_out  = reset && ctrl.if_id_flush;
    assign id_ex_flush_out  = reset && ctrl.id_ex_flush;
    assign mem_wb_flush_out = reset && ctrl.mem_wb_flush;
    assign ic_abort_out     = reset && ctrl.ic_abort;
    assign state_out        = state;
    assign stall_count_out  = stall_cnt;
    assign timeout_out      = tmo;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: priority table, multi-cycle cache/branch sequences,
// async reset mid-wait, and randomized traffic against a rule-level reference model.
module tb_pipeline_stall_ctrl;

    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_mem_read_in;
    logic [4:0]       ex_reg_dest_addr_in, id_reg_a_addr_in, id_reg_b_addr_in;
    logic             ex_branch_taken_in, ic_req_in, ic_ready_in, dc_req_in, dc_ready_in;
    logic             pc_stall_out, if_id_stall_out, id_ex_stall_out, ex_mem_stall_out;
    logic             if_id_flush_out, id_ex_flush_out, mem_wb_flush_out, ic_abort_out;
    logic [1:0]       state_out;
    logic [CNT_W-1:0] stall_count_out;
    logic             timeout_out;

    pipeline_stall_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .ex_mem_read_in(ex_mem_read_in), .ex_reg_dest_addr_in(ex_reg_dest_addr_in),
        .id_reg_a_addr_in(id_reg_a_addr_in), .id_reg_b_addr_in(id_reg_b_addr_in),
        .ex_branch_taken_in(ex_branch_taken_in),
        .ic_req_in(ic_req_in), .ic_ready_in(ic_ready_in),
        .dc_req_in(dc_req_in), .dc_ready_in(dc_ready_in),
        .pc_stall_out(pc_stall_out), .if_id_stall_out(if_id_stall_out),
        .id_ex_stall_out(id_ex_stall_out), .ex_mem_stall_out(ex_mem_stall_out),
        .if_id_flush_out(if_id_flush_out), .id_ex_flush_out(id_ex_flush_out),
        .mem_wb_flush_out(mem_wb_flush_out), .ic_abort_out(ic_abort_out),
        .state_out(state_out), .stall_count_out(stall_count_out), .timeout_out(timeout_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       mr;
        logic [4:0] dest, ra, rb;
        logic       br, icq, icr, dcq, dcr;
    } stim_t;

    typedef struct {
        string      name;
        stim_t      s;
        logic [7:0] ctrl;   // {pc,if_id,id_ex,ex_mem stall, if_id,id_ex,mem_wb flush, abort}
    } vec_t;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int m_st, m_cnt, m_run;
    bit m_tmo;

    function automatic stim_t mk(logic mr, int dest, int ra, int rb,
                                 logic br, logic icq, logic icr, logic dcq, logic dcr);
        stim_t s;
        s.mr = mr; s.dest = 5'(dest); s.ra = 5'(ra); s.rb = 5'(rb);
        s.br = br; s.icq = icq; s.icr = icr; s.dcq = dcq; s.dcr = dcr;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        ex_mem_read_in = s.mr; ex_reg_dest_addr_in = s.dest;
        id_reg_a_addr_in = s.ra; id_reg_b_addr_in = s.rb;
        ex_branch_taken_in = s.br; ic_req_in = s.icq; ic_ready_in = s.icr;
        dc_req_in = s.dcq; dc_ready_in = s.dcr;
    endtask

    function automatic logic [7:0] get_ctrl();
        return {pc_stall_out, if_id_stall_out, id_ex_stall_out, ex_mem_stall_out,
                if_id_flush_out, id_ex_flush_out, mem_wb_flush_out, ic_abort_out};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Expected controls straight from the priority rules.
    function automatic logic [7:0] exp_ctrl(input stim_t s, input int st);
        bit lu, dm, im;
        lu = s.mr && s.dest != 0 && (s.dest == s.ra || s.dest == s.rb);
        dm = s.dcq && !s.dcr;
        im = s.icq && !s.icr;
        if (dm)        return 8'hF2;
        else if (s.br) return (im || st == 1) ? 8'h0D : 8'h0C;
        else if (lu)   return 8'hC4;
        else if (im)   return 8'h88;
        else           return 8'h00;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_run = 0; m_tmo = 0;
    endtask

    task automatic model_edge(input stim_t s);
        logic [7:0] c;
        int nxt;
        bit dm, im;
        c  = exp_ctrl(s, m_st);
        dm = s.dcq && !s.dcr;
        im = s.icq && !s.icr;
        if (c[7] && m_cnt < CNT_MAX) m_cnt++;
        case (m_st)
            0:       nxt = dm ? 2 : (im && !s.br) ? 1 : 0;
            1:       nxt = dm ? 2 : (s.icr || s.br) ? 0 : 1;
            default: nxt = s.dcr ? 0 : 2;
        endcase
        if (m_st != 0) begin
            m_run++;
            if (m_run >= TIMEOUT) m_tmo = 1;
        end
        if (nxt != m_st) m_run = 0;
        m_st = nxt;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
    endtask

    // Inputs already driven; check this cycle then advance one clock.
    task automatic step_chk(input string nm, input logic [7:0] ec, input int est,
                            input int ecnt, input bit etmo);
        #3;
        chk({nm, ".ctrl"}, 32'(get_ctrl()), 32'(ec));
        chk({nm, ".state"}, 32'(state_out), 32'(est));
        chk({nm, ".cnt"}, 32'(stall_count_out), 32'(ecnt));
        chk({nm, ".tmo"}, 32'(timeout_out), 32'(etmo));
        @(posedge clk); #1;
    endtask

    vec_t tbl[$];

    initial begin
        stim_t s;
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        tbl.push_back('{"idle",      mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 8'h00});
        tbl.push_back('{"lu_rs2",    mk(1, 5, 1, 5, 0, 0, 0, 0, 0), 8'hC4});
        tbl.push_back('{"lu_rs1",    mk(1, 7, 7, 2, 0, 0, 0, 0, 0), 8'hC4});
        tbl.push_back('{"lu_x0",     mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 8'h00});
        tbl.push_back('{"nonload",   mk(0, 5, 5, 5, 0, 0, 0, 0, 0), 8'h00});
        tbl.push_back('{"dm",        mk(0, 0, 0, 0, 0, 0, 0, 1, 0), 8'hF2});
        tbl.push_back('{"dc_hit",    mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 8'h00});
        tbl.push_back('{"br",        mk(0, 0, 0, 0, 1, 0, 0, 0, 0), 8'h0C});
        tbl.push_back('{"br_im",     mk(0, 0, 0, 0, 1, 1, 0, 0, 0), 8'h0D});
        tbl.push_back('{"im",        mk(0, 0, 0, 0, 0, 1, 0, 0, 0), 8'h88});
        tbl.push_back('{"ic_hit",    mk(0, 0, 0, 0, 0, 1, 1, 0, 0), 8'h00});
        tbl.push_back('{"dm_br_lu",  mk(1, 3, 3, 0, 1, 1, 0, 1, 0), 8'hF2});
        tbl.push_back('{"br_lu",     mk(1, 3, 0, 3, 1, 0, 0, 0, 0), 8'h0C});
        tbl.push_back('{"lu_im",     mk(1, 9, 9, 9, 0, 1, 0, 0, 0), 8'hC4});

        // Reset state
        do_reset();
        #3;
        chk("rst.ctrl", 32'(get_ctrl()), 32'h0);
        chk("rst.state", 32'(state_out), 32'h0);
        chk("rst.cnt", 32'(stall_count_out), 32'h0);
        chk("rst.tmo", 32'(timeout_out), 32'h0);
        @(posedge clk); #1;

        // Priority table, each vector applied from a fresh RUN state
        foreach (tbl[i]) begin
            reset = 1'b0; #1; reset = 1'b1;
            drive(tbl[i].s);
            #2;
            chk({"tbl.", tbl[i].name}, 32'(get_ctrl()), 32'(tbl[i].ctrl));
            @(posedge clk); #1;
        end

        // Load-use produces a single bubble
        do_reset();
        drive(mk(1, 5, 1, 5, 0, 0, 0, 0, 0)); step_chk("lu0", 8'hC4, 0, 0, 0);
        drive(mk(0, 0, 1, 5, 0, 0, 0, 0, 0)); step_chk("lu1", 8'h00, 0, 1, 0);

        // D-cache miss for 3 cycles
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        step_chk("dm0", 8'hF2, 0, 0, 0);
        step_chk("dm1", 8'hF2, 2, 1, 0);
        step_chk("dm2", 8'hF2, 2, 2, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1)); step_chk("dm3", 8'h00, 2, 3, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); step_chk("dm4", 8'h00, 0, 3, 0);

        // Branch during IC_WAIT aborts the fetch
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        step_chk("ib0", 8'h88, 0, 0, 0);
        step_chk("ib1", 8'h88, 1, 1, 0);
        drive(mk(0, 0, 0, 0, 1, 1, 0, 0, 0)); step_chk("ib2", 8'h0D, 1, 2, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); step_chk("ib3", 8'h00, 0, 2, 0);

        // dm + br + lu together; br wins once the D-cache completes
        do_reset();
        drive(mk(1, 4, 4, 0, 1, 0, 0, 1, 0));
        step_chk("dbl0", 8'hF2, 0, 0, 0);
        step_chk("dbl1", 8'hF2, 2, 1, 0);
        drive(mk(1, 4, 4, 0, 1, 0, 0, 1, 1)); step_chk("dbl2", 8'h0C, 2, 2, 0);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0)); step_chk("dbl3", 8'h00, 0, 2, 0);

        // Long I-cache miss: watchdog and counter saturation
        do_reset();
        drive(mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int k = 0; k < 10; k++)
            step_chk($sformatf("wd%0d", k), 8'h88, (k == 0) ? 0 : 1,
                     (k < CNT_MAX) ? k : CNT_MAX, k >= TIMEOUT + 1);
        // Async reset mid-wait, no clock edge in between
        drive(mk(1, 2, 2, 2, 1, 1, 0, 1, 0));
        #2; reset = 1'b0; #1;
        chk("arst.ctrl", 32'(get_ctrl()), 32'h0);
        chk("arst.state", 32'(state_out), 32'h0);
        chk("arst.cnt", 32'(stall_count_out), 32'h0);
        chk("arst.tmo", 32'(timeout_out), 32'h0);

        // Randomized traffic vs reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i % 80 == 79) do_reset();
            s = mk($urandom % 2, $urandom % 4, $urandom % 4, $urandom % 4,
                   ($urandom % 4) == 0, $urandom % 2, ($urandom % 3) == 0,
                   ($urandom % 3) == 0, ($urandom % 3) == 0);
            drive(s);
            #3;
            chk("rnd.ctrl", 32'(get_ctrl()), 32'(exp_ctrl(s, m_st)));
            chk("rnd.state", 32'(state_out), 32'(m_st));
            chk("rnd.cnt", 32'(stall_count_out), 32'(m_cnt));
            chk("rnd.tmo", 32'(timeout_out), 32'(m_tmo));
            @(posedge clk);
            model_edge(s);
            #1;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
